// File: rtl/rvee_trap_ctrl.sv
// Machine-mode trap controller for the rvee pipeline.
//
// Captures exceptions reported by the mem stage into mepc/mcause/mtval.
// It then flushes the pipeline for one cycle and redirects fetch to mtvec
// on the following cycle. An mret retiring from exec flushes the pipeline
// and redirects to mepc in the next cycle. The block also holds the trap
// CSRs (mtvec, mscratch, mepc, mcause, mtval) behind a small combinational
// read / registered write port.
//
// Optional feature: define RVEE_TRAP_DOUBLE_FAULT_HALT_EN to turn an
// exception taken while in_trap is set into a halt. The halt state is
// left only through reset. Without the macro, nested exceptions are
// ordinary traps and halted is tied low.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   exception, fault_pc,      fault report from mem stage
//   fault_addr, n_cause
//   mret                      mret retiring from exec stage
//   csr_addr, csr_we,         CSR access (read combinational, write on edge)
//   csr_wdata, csr_rdata,
//   csr_illegal
//   flush, redirect,          registered pipeline control
//   redirect_pc
//   in_trap, halted           status

module rvee_trap_ctrl #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_TVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exception,
  input  logic [XLEN-1:0] fault_pc,
  input  logic [XLEN-1:0] fault_addr,
  input  logic [XLEN-2:0] n_cause,
  input  logic            mret,
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            in_trap,
  output logic            halted
);

  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;

  typedef enum logic [1:0] {StIdle, StEnter, StRedirect, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            in_trap_q, in_trap_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  // CSR read port
  always_comb begin
    csr_rdata   = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      AddrMtvec:    csr_rdata = mtvec_q;
      AddrMscratch: csr_rdata = mscratch_q;
      AddrMepc:     csr_rdata = mepc_q;
      AddrMcause:   csr_rdata = mcause_q;
      AddrMtval:    csr_rdata = mtval_q;
      default:      csr_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    in_trap_d     = in_trap_q;
    flush_d       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    // Software writes first; a trap capture below overrides mepc/mcause/mtval.
    if (csr_we && (state_q != StHalt)) begin
      case (csr_addr)
        AddrMtvec:    mtvec_d    = {csr_wdata[XLEN-1:2], 2'b00};
        AddrMscratch: mscratch_d = csr_wdata;
        AddrMepc:     mepc_d     = {csr_wdata[XLEN-1:2], 2'b00};
        AddrMcause:   mcause_d   = csr_wdata;
        AddrMtval:    mtval_d    = csr_wdata;
        default:      ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (exception) begin
          mepc_d    = {fault_pc[XLEN-1:2], 2'b00};
          mtval_d   = fault_addr;
          mcause_d  = {1'b0, n_cause};
          in_trap_d = 1'b1;
          flush_d   = 1'b1;
`ifdef RVEE_TRAP_DOUBLE_FAULT_HALT_EN
          state_d   = in_trap_q ? StHalt : StEnter;
`else
          state_d   = StEnter;
`endif
        end else if (mret) begin
          flush_d       = 1'b1;
          redirect_d    = 1'b1;
          redirect_pc_d = mepc_q;
          in_trap_d     = 1'b0;
        end
      end
      // flush is high during ENTER; exception/mret here are wrong-path
      StEnter: begin
        state_d       = StRedirect;
        redirect_d    = 1'b1;
        redirect_pc_d = mtvec_q;
      end
      StRedirect: state_d = StIdle;
      StHalt:     ;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      mtvec_q       <= {RESET_TVEC[XLEN-1:2], 2'b00};
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      in_trap_q     <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      in_trap_q     <= in_trap_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign in_trap     = in_trap_q;

`ifdef RVEE_TRAP_DOUBLE_FAULT_HALT_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_rvee_trap_ctrl.sv
module tb_rvee_trap_ctrl;

  localparam logic [31:0] ResetTvec = 32'h0000_0207;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception;
  logic [31:0] fault_pc;
  logic [31:0] fault_addr;
  logic [30:0] n_cause;
  logic        mret;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_trap;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  rvee_trap_ctrl #(
    .XLEN       (32),
    .RESET_TVEC (ResetTvec)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exception   (exception),
    .fault_pc    (fault_pc),
    .fault_addr  (fault_addr),
    .n_cause     (n_cause),
    .mret        (mret),
    .csr_addr    (csr_addr),
    .csr_we      (csr_we),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_trap     (in_trap),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_read(input logic [11:0] a, input string tag, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_we    = 1'b1;
    csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  // Raise exception for one edge.
  task automatic raise(input logic [31:0] pc, input logic [31:0] addr, input logic [30:0] c);
    exception  = 1'b1;
    fault_pc   = pc;
    fault_addr = addr;
    n_cause    = c;
    tick();
    exception = 1'b0;
  endtask

  initial begin
    rst = 1'b0; exception = 1'b0; fault_pc = '0; fault_addr = '0; n_cause = '0;
    mret = 1'b0; csr_addr = 12'h305; csr_we = 1'b0; csr_wdata = '0;
    #12;
    // Reset state
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_in_trap", {31'd0, in_trap}, 32'd0);
    csr_read(12'h305, "rst_mtvec", 32'h0000_0204);
    csr_read(12'h341, "rst_mepc", 32'd0);
    csr_read(12'h340, "rst_mscratch", 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic trap
    csr_write(12'h305, 32'h0000_0103);
    csr_read(12'h305, "mtvec_mask", 32'h0000_0100);
    csr_addr = 12'h341;
    raise(32'h0000_0040, 32'h0000_1001, 31'd4);
    check("trap_flush_n1", {31'd0, flush}, 32'd1);
    check("trap_redir_n1", {31'd0, redirect}, 32'd0);
    check("trap_in_trap", {31'd0, in_trap}, 32'd1);
    tick();
    check("trap_flush_n2", {31'd0, flush}, 32'd0);
    check("trap_redir_n2", {31'd0, redirect}, 32'd1);
    check("trap_redir_pc", redirect_pc, 32'h0000_0100);
    tick();
    check("trap_redir_n3", {31'd0, redirect}, 32'd0);
    csr_read(12'h341, "trap_mepc", 32'h0000_0040);
    csr_read(12'h342, "trap_mcause", 32'd4);
    csr_read(12'h343, "trap_mtval", 32'h0000_1001);

    // mret
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_flush", {31'd0, flush}, 32'd1);
    check("mret_redir", {31'd0, redirect}, 32'd1);
    check("mret_pc", redirect_pc, 32'h0000_0040);
    check("mret_in_trap", {31'd0, in_trap}, 32'd0);
    tick();
    check("mret_flush_clr", {31'd0, flush}, 32'd0);

    // exception and mret together; exception re-asserted in ENTER
    mret = 1'b1;
    raise(32'h0000_0080, 32'd0, 31'd2);
    mret = 1'b0;
    check("both_flush", {31'd0, flush}, 32'd1);
    check("both_redir", {31'd0, redirect}, 32'd0);
    exception = 1'b1; fault_pc = 32'h0000_0200; n_cause = 31'd7;
    tick();
    exception = 1'b0;
    check("both_redir_n2", {31'd0, redirect}, 32'd1);
    check("both_pc", redirect_pc, 32'h0000_0100);
    tick();
    check("both_flush_after", {31'd0, flush}, 32'd0);
    csr_read(12'h341, "both_mepc", 32'h0000_0080);
    csr_read(12'h342, "both_mcause", 32'd2);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();

    // CSR write collides with trap capture
    csr_addr = 12'h341; csr_we = 1'b1; csr_wdata = 32'hDEAD_BEEF;
    raise(32'h0000_00C7, 32'h0000_0055, 31'd5);
    csr_we = 1'b0;
    csr_read(12'h341, "collide_mepc", 32'h0000_00C4);
    tick(); tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_pc2", redirect_pc, 32'h0000_00C4);
    tick();

    // CSR map
    csr_write(12'h341, 32'h0000_0123);
    csr_read(12'h341, "mepc_mask", 32'h0000_0120);
    csr_write(12'h340, 32'hFFFF_FFFF);
    csr_read(12'h340, "mscratch", 32'hFFFF_FFFF);
    csr_write(12'h342, 32'h8000_000B);
    csr_read(12'h342, "mcause_wr", 32'h8000_000B);
    csr_write(12'h7C0, 32'h1234_5678);
    csr_read(12'h7C0, "unmapped_rdata", 32'd0);
    check("unmapped_illegal", {31'd0, csr_illegal}, 32'd1);
    csr_read(12'h343, "mtval_keep", 32'h0000_0055);
    check("mapped_illegal", {31'd0, csr_illegal}, 32'd0);

    // Nested exception
    raise(32'h0000_0300, 32'd0, 31'd1);
    tick(); tick();
    check("nest_in_trap", {31'd0, in_trap}, 32'd1);
    raise(32'h0000_0400, 32'd0, 31'd3);
    check("nest_flush", {31'd0, flush}, 32'd1);
`ifdef RVEE_TRAP_DOUBLE_FAULT_HALT_EN
    tick();
    check("dbl_halted", {31'd0, halted}, 32'd1);
    check("dbl_redir", {31'd0, redirect}, 32'd0);
    csr_write(12'h340, 32'h0000_0001);
    csr_read(12'h340, "dbl_csr_ignored", 32'hFFFF_FFFF);
    tick();
    check("dbl_redir2", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    #1;
    check("dbl_rst_halted", {31'd0, halted}, 32'd0);
    csr_read(12'h305, "dbl_rst_mtvec", 32'h0000_0204);
    @(negedge clk);
    rst = 1'b1;
    tick();
    csr_write(12'h305, 32'h0000_0100);
`else
    tick();
    check("nest_redir", {31'd0, redirect}, 32'd1);
    check("nest_pc", redirect_pc, 32'h0000_0100);
    check("nest_halted", {31'd0, halted}, 32'd0);
    csr_read(12'h341, "nest_mepc", 32'h0000_0400);
    tick();
`endif

    // Reset during ENTER aborts the redirect
    raise(32'h0000_0500, 32'd0, 31'd6);
    check("abort_flush", {31'd0, flush}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_flush_rst", {31'd0, flush}, 32'd0);
    check("abort_in_trap", {31'd0, in_trap}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_redir", {31'd0, redirect}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvee_trap_ctrl.md
RVEE_TRAP_CTRL -- requirements
Module: rvee_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RESET_TVEC, default 32'h0000_0000, mtvec reset value.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port exception  input  1  fault reported by mem stage this cycle.
REQ-006 SHALL have port fault_pc  input  XLEN  PC of faulting instruction.
REQ-007 SHALL have port fault_addr  input  XLEN  faulting address / tval.
REQ-008 SHALL have port n_cause  input  XLEN-1  exception cause code.
REQ-009 SHALL have port mret  input  1  mret retiring from exec stage.
REQ-010 SHALL have ports csr_addr  input  12, csr_we  input  1, csr_wdata  input  XLEN  CSR write access.
REQ-011 SHALL have ports csr_rdata  output  XLEN, csr_illegal  output  1  CSR read result / unmapped address.
REQ-012 SHALL have ports flush  output  1, redirect  output  1, redirect_pc  output  XLEN  pipeline control.
REQ-013 SHALL have ports in_trap  output  1, halted  output  1  status.

Function
REQ-014 SHALL implement FSM states IDLE, ENTER, REDIRECT, HALT.
REQ-015 IDLE with exception=1 at edge N SHALL: mepc<=fault_pc with [1:0]=0, mtval<=fault_addr, mcause<={1'b0,n_cause}, in_trap<=1, state<=ENTER.
REQ-016 ENTER SHALL drive flush=1 for exactly one cycle, then go to REDIRECT.
REQ-017 REDIRECT SHALL drive redirect=1, redirect_pc={mtvec[XLEN-1:2],2'b00} for one cycle, then go to IDLE; trap latency exception->redirect = 2 cycles.
REQ-018 exception and mret SHALL be ignored in ENTER and REDIRECT (wrong-path).
REQ-019 IDLE with mret=1 and exception=0 SHALL drive flush=1, redirect=1, redirect_pc=mepc in the following cycle, and clear in_trap; mret with in_trap=0 behaves identically.
REQ-020 exception and mret in the same IDLE cycle: exception SHALL win, mret dropped.
REQ-021 CSR map: 12'h305 mtvec, 12'h340 mscratch, 12'h341 mepc, 12'h342 mcause, 12'h343 mtval; csr_rdata combinational from csr_addr.
REQ-022 mtvec and mepc writes SHALL force bits [1:0] to 0; other CSRs store all XLEN bits.
REQ-023 unmapped csr_addr SHALL give csr_rdata=0, csr_illegal=1, writes discarded.
REQ-024 csr_we to mepc/mcause/mtval in the cycle a trap is captured SHALL lose to the hardware update; writes to mtvec/mscratch proceed.
REQ-025 csr_we SHALL be accepted in every state except HALT.
REQ-026 outputs flush/redirect SHALL be registered (no combinational path from exception/mret).

Reset
REQ-027 rst=0 SHALL asynchronously set state=IDLE, mtvec=RESET_TVEC with [1:0]=0, mepc=mcause=mtval=mscratch=0, in_trap=0.
REQ-028 during reset flush=0, redirect=0, redirect_pc=0, halted=0.
REQ-029 reset asserted in ENTER/REDIRECT/HALT SHALL abort the sequence; no redirect after release.

Configuration
REQ-030 macro RVEE_TRAP_DOUBLE_FAULT_HALT_EN defined: exception in IDLE with in_trap=1 SHALL capture CSRs as REQ-015, drive flush=1, enter HALT; HALT asserts halted=1, ignores all inputs except rst.
REQ-031 macro undefined: nested exception SHALL be handled as a normal trap (REQ-015..017), HALT unreachable, halted tied 0.

Verification
REQ-032 write mtvec=32'h0000_0103, exception with fault_pc=32'h0000_0040, fault_addr=32'h0000_1001, n_cause=4 -> flush at N+1, redirect at N+2 with redirect_pc=32'h0000_0100; mepc=0x40, mcause=4, mtval=0x1001.
REQ-033 after REQ-032 trap, mret -> next cycle flush=1, redirect=1, redirect_pc=32'h0000_0040, in_trap=0.
REQ-034 exception and mret same cycle (fault_pc=0x80, n_cause=2) -> trap taken, mepc=0x80, redirect_pc=mtvec; exception re-asserted during ENTER -> no second capture.
REQ-035 csr_we to 12'h341 with 32'hDEAD_BEEF in trap-capture cycle -> mepc=fault_pc; read 12'h7C0 -> csr_rdata=0, csr_illegal=1.
REQ-036 with RVEE_TRAP_DOUBLE_FAULT_HALT_EN, second exception while in_trap=1 -> halted=1, no redirect; rst low -> halted=0, mtvec=RESET_TVEC; without macro -> second trap redirects to mtvec.
